// File: rtl/fpu_cp_pkg.sv
// Shared constants and types for the 68881-style coprocessor bus slave
// and its extended-register sequencer.
package fpu_cp_pkg;

    localparam logic [4:0] ADDR_FPCR  = 5'b01000;
    localparam logic [4:0] ADDR_FPSR  = 5'b01001;
    localparam logic [4:0] ADDR_FPIAR = 5'b01010;

    // Acknowledge encodings, packed as {DSACK1, DSACK0}, both active-low.
    localparam logic [1:0] DSACK_32   = 2'b01;
    localparam logic [1:0] DSACK_16   = 2'b10;
    localparam logic [1:0] DSACK_IDLE = 2'b11;

    localparam logic [1:0] PH_LO  = 2'd0;
    localparam logic [1:0] PH_MID = 2'd1;
    localparam logic [1:0] PH_HI  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        CYC_FETCH,
        CYC_READ,
        CYC_WRITE
    } cyc_e;

    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        return (ph == PH_HI) ? PH_LO : ph + 2'd1;
    endfunction

endpackage

// File: rtl/fpu_xreg_seq.sv
// Extended register file with 32/32/16 subcycle sequencing: phase pointer,
// register/direction tag, write shadow for atomic commit and read snapshot.
module fpu_xreg_seq
    import fpu_cp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        acc_en,
    input  logic        clr_ptr,
    input  logic [2:0]  reg_sel,
    input  logic        is_read,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic        ack16
);

    logic [1:0]  ptr_q, ptr_d;
    logic [2:0]  tag_reg_q, tag_reg_d;
    logic        tag_rd_q, tag_rd_d;
    logic [63:0] shadow_q, shadow_d;
    logic [79:0] snap_q, snap_d;
    // Eight slots always exist; the top only enables accesses to mapped
    // registers, so unmapped slots stay at their reset value.
    logic [79:0] fp_q [8];
    logic [79:0] fp_d [8];
    logic [1:0]  phase;

    always_comb begin
        phase = PH_LO;
        if (reg_sel == tag_reg_q && is_read == tag_rd_q) begin
            phase = ptr_q;
        end
    end

    assign ack16 = (phase == PH_HI);

    always_comb begin
        case (phase)
            PH_LO:   rd_data = fp_q[reg_sel][31:0];
            PH_MID:  rd_data = snap_q[63:32];
            default: rd_data = {16'h0000, snap_q[79:64]};
        endcase
    end

    // NOTE: every _d gets its current value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ptr_d     = ptr_q;
        tag_reg_d = tag_reg_q;
        tag_rd_d  = tag_rd_q;
        shadow_d  = shadow_q;
        snap_d    = snap_q;
        fp_d      = fp_q;
        if (clr_ptr) begin
            ptr_d = PH_LO;
        end else if (acc_en) begin
            ptr_d     = next_phase(phase);
            tag_reg_d = reg_sel;
            tag_rd_d  = is_read;
            if (is_read) begin
                if (phase == PH_LO) begin
                    snap_d = fp_q[reg_sel];
                end
            end else begin
                case (phase)
                    PH_LO:   shadow_d[31:0]  = wdata;
                    PH_MID:  shadow_d[63:32] = wdata;
                    default: fp_d[reg_sel]   = {wdata[15:0], shadow_q};
                endcase
            end
        end
    end

    // NOTE: the register file is reset along with the control state because
    // the architectural state after reset must be all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= PH_LO;
            tag_reg_q <= '0;
            tag_rd_q  <= 1'b0;
            shadow_q  <= '0;
            snap_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                fp_q[i] <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples the pre-edge values of the others.
            ptr_q     <= ptr_d;
            tag_reg_q <= tag_reg_d;
            tag_rd_q  <= tag_rd_d;
            shadow_q  <= shadow_d;
            snap_q    <= snap_d;
            fp_q      <= fp_d;
        end
    end

endmodule

// File: rtl/fpu_cp_bus_if.sv
// 68881-style asynchronous coprocessor bus slave: cycle FSM, address decode,
// control registers, opcode hand-off and the tri-state data driver.
module fpu_cp_bus_if
    import fpu_cp_pkg::*;
#(
    parameter int NUM_FPREGS = 8,
    parameter int ACK_WAIT   = 1
)(
    input  logic        CLK,
    input  logic        RESET,
    output logic        SENSE,
    input  logic        SIZE,
    input  logic [4:0]  A,
    inout  wire  [31:0] D,
    input  logic        AS,
    input  logic        DS,
    input  logic        R_W,
    input  logic        CS,
    output logic        DSACK0,
    output logic        DSACK1,
    output logic [31:0] CMD,
    output logic        CMD_VALID
);

    localparam logic [3:0] NREG      = 4'(NUM_FPREGS);
    localparam logic [3:0] WAIT_LOAD = 4'(ACK_WAIT - 1);

    state_e      state_q, state_d;
    cyc_e        cyc_q, cyc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  addr_q, addr_d;
    logic [1:0]  dsack_q, dsack_d;
    logic        drive_q, drive_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        sense_q, sense_d;
    logic [15:0] fpcr_q, fpcr_d;
    logic [31:0] fpsr_q, fpsr_d;
    logic [31:0] fpiar_q, fpiar_d;

    logic        strobe;
    logic        a_mapped;
    logic        fp_sel;
    logic        xr_acc;
    logic        xr_clr;
    logic [31:0] xr_rd;
    logic        xr_ack16;

    // Transfer width follows the subcycle phase, so the port size is not used.
    wire unused_size = SIZE;

    assign strobe   = CS & AS;
    assign a_mapped = ((A[4:3] == 2'b00) && ({1'b0, A[2:0]} < NREG))
                    || (A == ADDR_FPCR) || (A == ADDR_FPSR) || (A == ADDR_FPIAR);
    assign fp_sel   = (addr_q[4:3] == 2'b00);

    fpu_xreg_seq u_xreg (
        .clk     (CLK),
        .reset   (RESET),
        .acc_en  (xr_acc),
        .clr_ptr (xr_clr),
        .reg_sel (addr_q[2:0]),
        .is_read (cyc_q == CYC_READ),
        .wdata   (D),
        .rd_data (xr_rd),
        .ack16   (xr_ack16)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        dsack_d     = dsack_q;
        drive_d     = drive_q;
        rdata_d     = rdata_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        sense_d     = 1'b1;
        fpcr_d      = fpcr_q;
        fpsr_d      = fpsr_q;
        fpiar_d     = fpiar_q;
        xr_acc      = 1'b0;
        xr_clr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (strobe && !DS && R_W) begin
                    cyc_d   = CYC_FETCH;
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_WAIT;
                end else if (strobe && DS) begin
                    cyc_d   = R_W ? CYC_READ : CYC_WRITE;
                    addr_d  = A;
                    cnt_d   = WAIT_LOAD;
                    state_d = a_mapped ? ST_WAIT : ST_HOLD;
                end
            end

            ST_WAIT: begin
                if (!strobe) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_ACK;
                    dsack_d = DSACK_32;
                    case (cyc_q)
                        CYC_FETCH: begin
                            cmd_d       = D;
                            cmd_valid_d = 1'b1;
                            xr_clr      = 1'b1;
                        end
                        CYC_WRITE: begin
                            if (fp_sel) begin
                                xr_acc = 1'b1;
                                if (xr_ack16) dsack_d = DSACK_16;
                            end else begin
                                xr_clr = 1'b1;
                                case (addr_q)
                                    ADDR_FPCR: fpcr_d  = D[15:0];
                                    ADDR_FPSR: fpsr_d  = D;
                                    default:   fpiar_d = D;
                                endcase
                            end
                        end
                        default: begin
                            drive_d = 1'b1;
                            if (fp_sel) begin
                                xr_acc  = 1'b1;
                                rdata_d = xr_rd;
                                if (xr_ack16) dsack_d = DSACK_16;
                            end else begin
                                xr_clr = 1'b1;
                                case (addr_q)
                                    ADDR_FPCR: rdata_d = {16'h0000, fpcr_q};
                                    ADDR_FPSR: rdata_d = fpsr_q;
                                    default:   rdata_d = fpiar_q;
                                endcase
                            end
                        end
                    endcase
                end
            end

            ST_ACK: begin
                if (!strobe) begin
                    state_d = ST_IDLE;
                    dsack_d = DSACK_IDLE;
                    drive_d = 1'b0;
                end
            end

            ST_HOLD: begin
                if (!strobe) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cyc_q       <= CYC_FETCH;
            cnt_q       <= '0;
            addr_q      <= '0;
            dsack_q     <= DSACK_IDLE;
            drive_q     <= 1'b0;
            rdata_q     <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            sense_q     <= 1'b0;
            fpcr_q      <= '0;
            fpsr_q      <= '0;
            fpiar_q     <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            dsack_q     <= dsack_d;
            drive_q     <= drive_d;
            rdata_q     <= rdata_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            sense_q     <= sense_d;
            fpcr_q      <= fpcr_d;
            fpsr_q      <= fpsr_d;
            fpiar_q     <= fpiar_d;
        end
    end

    // The bus is let go the moment the host drops either strobe, not a clock later.
    assign D         = (drive_q && strobe) ? rdata_q : 32'bz;
    assign DSACK1    = dsack_q[1];
    assign DSACK0    = dsack_q[0];
    assign SENSE     = sense_q;
    assign CMD       = cmd_q;
    assign CMD_VALID = cmd_valid_q;

endmodule

// File: tb/tb_fpu_cp_bus_if.sv
// Self-checking bench: table of bus cycles with a scoreboard of expected
// acks/data, plus hand-written sequences for reset, unmapped and abort cases.
module tb_fpu_cp_bus_if;

    localparam int         NREGS = 4;
    localparam int         WAITS = 3;
    localparam logic [1:0] ACK32 = 2'b01;
    localparam logic [1:0] ACK16 = 2'b10;
    localparam logic [1:0] NOACK = 2'b11;
    localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {K_FETCH, K_RD, K_WR} kind_e;

    typedef struct {
        kind_e       k;
        logic [4:0]  a;
        logic [31:0] wd;
        logic [1:0]  ack;
        logic [31:0] rd;
        string       name;
    } vec_t;

    typedef struct {
        logic [1:0]  ack;
        logic [31:0] rd;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SENSE;
    logic        SIZE;
    logic [4:0]  A;
    wire  [31:0] D;
    logic        AS, DS, R_W, CS;
    logic        DSACK0, DSACK1;
    logic [31:0] CMD;
    logic        CMD_VALID;

    logic [31:0] tb_d;
    logic        tb_drv;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs[$];
    exp_t sb_q[$];

    assign D = tb_drv ? tb_d : 32'bz;
    pullup (D);

    always #5 CLK = ~CLK;

    fpu_cp_bus_if #(
        .NUM_FPREGS (NREGS),
        .ACK_WAIT   (WAITS)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SENSE     (SENSE),
        .SIZE      (SIZE),
        .A         (A),
        .D         (D),
        .AS        (AS),
        .DS        (DS),
        .R_W       (R_W),
        .CS        (CS),
        .DSACK0    (DSACK0),
        .DSACK1    (DSACK1),
        .CMD       (CMD),
        .CMD_VALID (CMD_VALID)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, want %08h", name, act, exp);
    endtask

    task automatic add(input kind_e k, input logic [4:0] a, input logic [31:0] wd,
                       input logic [1:0] ack, input logic [31:0] rd, input string name);
        vec_t v;
        v.k = k; v.a = a; v.wd = wd; v.ack = ack; v.rd = rd; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic idle_bus();
        AS = 1'b0; CS = 1'b0; DS = 1'b0; R_W = 1'b1; tb_drv = 1'b0;
    endtask

    // One full bus cycle: drive, wait for ack (bounded), compare against the
    // scoreboard entry, then drop the strobes and confirm the release.
    task automatic bus_cycle(input kind_e k, input logic [4:0] a, input logic [31:0] wd,
                             input logic [1:0] ack, input logic [31:0] rd, input string name);
        exp_t e;
        int   n;
        @(negedge CLK);
        A = a; R_W = (k != K_WR); DS = (k != K_FETCH);
        tb_d = wd; tb_drv = (k != K_RD); CS = 1'b1; AS = 1'b1;
        sb_q.push_back('{ack: ack, rd: rd});
        n = 0;
        while ({DSACK1, DSACK0} == NOACK && n < 40) begin
            @(negedge CLK);
            n++;
        end
        e = sb_q.pop_front();
        check({name, "_latency"}, 32'(n - 1), 32'(WAITS));
        check({name, "_ack"}, {30'd0, DSACK1, DSACK0}, {30'd0, e.ack});
        if (k == K_RD) check({name, "_data"}, D, e.rd);
        if (k == K_FETCH) begin
            check({name, "_cmd"}, CMD, e.rd);
            check({name, "_cmd_valid"}, {31'd0, CMD_VALID}, 32'd1);
        end
        idle_bus();
        #1;
        if (k == K_RD) check({name, "_d_release"}, D, RELEASED);
        @(negedge CLK);
        check({name, "_ack_release"}, {30'd0, DSACK1, DSACK0}, {30'd0, NOACK});
        if (k == K_FETCH) check({name, "_cmd_pulse_end"}, {31'd0, CMD_VALID}, 32'd0);
    endtask

    initial begin
        int n;

        SIZE = 1'b1; A = '0; tb_d = '0;
        idle_bus();
        RESET = 1'b1;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_sense", {31'd0, SENSE}, 32'd0);
        check("rst_dsack", {30'd0, DSACK1, DSACK0}, {30'd0, NOACK});
        check("rst_d", D, RELEASED);
        check("rst_cmd", CMD, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("sense_up", {31'd0, SENSE}, 32'd1);

        // Opcode fetch; A is ignored for fetches
        bus_cycle(K_FETCH, 5'b11111, 32'hCAFE_BABE, ACK32, 32'hCAFE_BABE, "fetch");

        add(K_WR, 5'b01000, 32'hA5A5_A5A5, ACK32, 32'h0,          "fpcr_wr");
        add(K_RD, 5'b01000, 32'h0,         ACK32, 32'h0000_A5A5, "fpcr_rd");
        add(K_WR, 5'b01001, 32'h1234_5678, ACK32, 32'h0,          "fpsr_wr");
        add(K_RD, 5'b01001, 32'h0,         ACK32, 32'h1234_5678, "fpsr_rd");
        add(K_WR, 5'b01010, 32'h0BAD_F00D, ACK32, 32'h0,          "fpiar_wr");
        add(K_RD, 5'b01010, 32'h0,         ACK32, 32'h0BAD_F00D, "fpiar_rd");
        add(K_WR, 5'b00011, 32'hDEAD_BEEF, ACK32, 32'h0,          "fp3_wr0");
        add(K_WR, 5'b00011, 32'hCAFE_BABE, ACK32, 32'h0,          "fp3_wr1");
        add(K_WR, 5'b00011, 32'hABCD_1234, ACK16, 32'h0,          "fp3_wr2");
        add(K_RD, 5'b00011, 32'h0,         ACK32, 32'hDEAD_BEEF, "fp3_rd0");
        add(K_RD, 5'b00011, 32'h0,         ACK32, 32'hCAFE_BABE, "fp3_rd1");
        add(K_RD, 5'b00011, 32'h0,         ACK16, 32'h0000_1234, "fp3_rd2");
        add(K_WR, 5'b00000, 32'h0123_4567, ACK32, 32'h0,          "fp0_wr0");
        add(K_WR, 5'b00000, 32'h89AB_CDEF, ACK32, 32'h0,          "fp0_wr1");
        add(K_WR, 5'b00000, 32'hFFFF_5555, ACK16, 32'h0,          "fp0_wr2");
        add(K_WR, 5'b00000, 32'h1111_1111, ACK32, 32'h0,          "fp0_abandon");
        add(K_RD, 5'b00000, 32'h0,         ACK32, 32'h0123_4567, "fp0_rd0");
        add(K_RD, 5'b00000, 32'h0,         ACK32, 32'h89AB_CDEF, "fp0_rd1");
        add(K_RD, 5'b00000, 32'h0,         ACK16, 32'h0000_5555, "fp0_rd2");
        add(K_WR, 5'b00001, 32'h7777_7777, ACK32, 32'h0,          "fp1_wr_cut");
        add(K_RD, 5'b01000, 32'h0,         ACK32, 32'h0000_A5A5, "fpcr_rd_mid");
        add(K_WR, 5'b00001, 32'h8888_8888, ACK32, 32'h0,          "fp1_wr0");
        add(K_WR, 5'b00001, 32'h9999_9999, ACK32, 32'h0,          "fp1_wr1");
        add(K_WR, 5'b00001, 32'h0000_AAAA, ACK16, 32'h0,          "fp1_wr2");
        add(K_RD, 5'b00001, 32'h0,         ACK32, 32'h8888_8888, "fp1_rd0");
        add(K_RD, 5'b00001, 32'h0,         ACK32, 32'h9999_9999, "fp1_rd1");
        add(K_RD, 5'b00001, 32'h0,         ACK16, 32'h0000_AAAA, "fp1_rd2");

        foreach (vecs[i]) begin
            bus_cycle(vecs[i].k, vecs[i].a, vecs[i].wd, vecs[i].ack, vecs[i].rd, vecs[i].name);
        end

        // FP5 is unmapped with four registers: no ack, then back to IDLE
        @(negedge CLK);
        A = 5'b00101; R_W = 1'b1; DS = 1'b1; tb_drv = 1'b0; CS = 1'b1; AS = 1'b1;
        repeat (10) @(negedge CLK);
        check("unmapped_noack", {30'd0, DSACK1, DSACK0}, {30'd0, NOACK});
        check("unmapped_d", D, RELEASED);
        idle_bus();
        @(negedge CLK);
        bus_cycle(K_RD, 5'b01001, 32'h0, ACK32, 32'h1234_5678, "after_unmapped");

        // Strobe loss during WAIT: no ack and no register update
        @(negedge CLK);
        A = 5'b01000; R_W = 1'b0; DS = 1'b1; tb_d = 32'h0000_FFFF; tb_drv = 1'b1;
        CS = 1'b1; AS = 1'b1;
        @(negedge CLK);
        idle_bus();
        repeat (4) @(negedge CLK);
        check("abort_noack", {30'd0, DSACK1, DSACK0}, {30'd0, NOACK});
        bus_cycle(K_RD, 5'b01000, 32'h0, ACK32, 32'h0000_A5A5, "abort_fpcr");

        // Reset while in ACK with the strobes still asserted
        @(negedge CLK);
        A = 5'b01001; R_W = 1'b1; DS = 1'b1; tb_drv = 1'b0; CS = 1'b1; AS = 1'b1;
        n = 0;
        while ({DSACK1, DSACK0} == NOACK && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("rst_ack_pre", {30'd0, DSACK1, DSACK0}, {30'd0, ACK32});
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_ack_dsack", {30'd0, DSACK1, DSACK0}, {30'd0, NOACK});
        check("rst_ack_d", D, RELEASED);
        check("rst_ack_sense", {31'd0, SENSE}, 32'd0);
        idle_bus();
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_ack_sense_up", {31'd0, SENSE}, 32'd1);
        bus_cycle(K_RD, 5'b01001, 32'h0, ACK32, 32'h0000_0000, "fpsr_cleared");
        bus_cycle(K_RD, 5'b00011, 32'h0, ACK32, 32'h0000_0000, "fp3_cleared");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_cp_bus_if.md
Name: fpu_cp_bus_if

Overview:
- Parametrised successor to the single-register 68881 pin wrapper.
- Implements the 68881-style asynchronous coprocessor bus slave: F-line opcode fetch, FPCR/FPSR/FPIAR control registers, and an N-entry 80-bit extended register file transferred in 32/32/16 subcycles.
- Adds configurable DSACK wait states, atomic 80-bit commit/snapshot, direction-aware subcycle sequencing, and a command hand-off to the execution core.
- Sits between the CPU bus pins and the FPU datapath.

Parameters:
- NUM_FPREGS, 8, number of extended registers (1..8).
- ACK_WAIT, 1, clocks from strobe sample to DSACK assertion (1..15).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- SENSE  out  1  interface ready.
- SIZE  in  1  1 = 32-bit port. Accepted but ignored; transfer width is set by the subcycle phase.
- A  in  5  register select.
- D  inout  32  data bus, tri-stated unless driving read data.
- AS  in  1  address strobe, active-high.
- DS  in  1  data strobe, active-high.
- R_W  in  1  1 = read.
- CS  in  1  chip select, active-high.
- DSACK0  out  1  active-low ack, 16-bit.
- DSACK1  out  1  active-low ack, 32-bit.
- CMD  out  32  last fetched opcode.
- CMD_VALID  out  1  one-cycle pulse on opcode capture.

Behaviour:
- Reset (synchronous, active-high; also applies mid-cycle):
  - DSACK0 = DSACK1 = 1, D = Z, SENSE = 0, CMD = 0, CMD_VALID = 0.
  - All registers, shadows and phase pointer cleared.
  - FSM forced to IDLE.
- SENSE: rises on the first edge with RESET low; stays 1 until the next reset.
- Cycle classes, sampled at a rising edge in IDLE:
  - fetch = CS & AS & ~DS & R_W.
  - read = CS & AS & DS & R_W.
  - write = CS & AS & DS & ~R_W.
- Address map:
  - 00nnn: FPn, mapped only if n < NUM_FPREGS.
  - 01000: FPCR. Bits [15:0] RW; [31:16] read 0.
  - 01001: FPSR, 32-bit RW.
  - 01010: FPIAR, 32-bit RW.
  - Any other address is unmapped. A fetch ignores A.
- FSM states: IDLE, WAIT, ACK, HOLD.
  - IDLE -> WAIT on a valid cycle. Counter loads ACK_WAIT-1.
  - WAIT -> ACK when the counter reaches 0. DSACK goes low at the edge ACK_WAIT clocks after the sampling edge.
  - At the ACK entry edge:
    - write/fetch data is captured from D;
    - read data is registered and D is driven.
  - ACK holds DSACK until an edge samples CS=0 or AS=0, then -> IDLE with DSACK released at that edge.
  - D is released combinationally as soon as CS or AS is low.
  - Unmapped address -> HOLD: no DSACK (host times out); -> IDLE when CS or AS is low.
  - Strobe loss in WAIT -> IDLE with no ack and no side effects.
- DSACK encoding:
  - 32-bit: DSACK1=0, DSACK0=1.
  - 16-bit: DSACK1=1, DSACK0=0.
  - Idle: both 1.
  - Control registers and fetch always use 32-bit.
- FPn sequencing uses one phase pointer (0 = low32 [31:0], 1 = mid32 [63:32], 2 = high16 [79:64]) plus a tag of the last register and direction.
  - Pointer resets to 0 if the register or direction differs from the tag.
  - Pointer advances on each acked access and wraps 2 -> 0.
  - Phase 2 uses D[15:0], acks 16-bit, and drives D[31:16] = 0 on read.
- Write atomicity: phases 0 and 1 fill a shadow; phase 2 commits all 80 bits to FPn in one edge. An abandoned sequence never alters FPn.
- Read snapshot: phase 0 snapshots FPn; phases 1 and 2 return snapshot data.
- Any control-register or fetch access resets the pointer to 0.
- Fetch: CMD <= D at ACK entry. CMD_VALID pulses high for exactly that one clock.

Decomposition:
- Package fpu_cp_pkg holds:
  - address constants (ADDR_FPCR, ADDR_FPSR, ADDR_FPIAR);
  - DSACK encodings (DSACK_32, DSACK_16, DSACK_IDLE);
  - the state enum;
  - phase constants.
- One sub-module, fpu_xreg_seq: phase pointer, tag compare, shadow/snapshot and register file. The top level keeps the FSM, decode and the tri-state driver.

Test Plan:
- Reset:
  - RESET high 2 clocks -> SENSE = 0, DSACK = 11, D = Z.
  - SENSE = 1 one edge after RESET falls.
- Fetch, with D = CAFEBABE and ACK_WAIT = 3:
  - DSACK1 = 0 exactly 3 clocks after the sampling edge.
  - CMD = CAFEBABE, CMD_VALID high for one cycle.
- FPCR:
  - Write A5A5A5A5 then read -> DSACK1 = 0, D = 0000A5A5.
  - FPSR write/read of 12345678 returns 12345678.
- FP3 extended transfer:
  - Write DEADBEEF, CAFEBABE, 1234 -> acks are DSACK1, DSACK1, DSACK0.
  - Read back -> DEADBEEF, CAFEBABE, 00001234.
- Abandoned write:
  - FP0 phase-0 write 11111111, then a read of FP0 -> pointer resets; read returns the old value, unchanged.
- Boundaries:
  - With NUM_FPREGS = 4, access to A = 00101 -> no DSACK; FSM returns to IDLE when AS drops.
  - RESET asserted in ACK -> DSACK = 11 and D = Z at the next edge.
